// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : main_fsm
//  Purpose  : Multicycle RV32 control FSM (Moore) with retired-instruction
//             counter. Optional macro ILLEGAL_OP_TRAP_EN traps unknown opcodes.
//  Revision : 1.0 - initial release
// ============================================================================
module main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             Branch,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount,
    output logic             IllegalOp
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECUTER = 4'd6;
    localparam logic [3:0] c_EXECUTEI = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BEQ      = 4'd9;
    localparam logic [3:0] c_JAL      = 4'd10;
    localparam logic [3:0] c_ERROR    = 4'd11;

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_retire;

    // State register and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = c_FETCH;
        case (state_q)
            c_FETCH:    state_d = c_DECODE;
            c_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: state_d = c_MEMADR;
                    c_OP_R:           state_d = c_EXECUTER;
                    c_OP_I:           state_d = c_EXECUTEI;
                    c_OP_BEQ:         state_d = c_BEQ;
                    c_OP_JAL:         state_d = c_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:          state_d = c_ERROR;
`else
                    default:          state_d = c_FETCH;
`endif
                endcase
            end
            c_MEMADR:   state_d = (op == c_OP_LW) ? c_MEMREAD : c_MEMWRITE;
            c_MEMREAD:  state_d = c_MEMWB;
            c_MEMWB:    state_d = c_FETCH;
            c_MEMWRITE: state_d = c_FETCH;
            c_EXECUTER: state_d = c_ALUWB;
            c_EXECUTEI: state_d = c_ALUWB;
            c_ALUWB:    state_d = c_FETCH;
            c_BEQ:      state_d = c_FETCH;
            c_JAL:      state_d = c_ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
            c_ERROR:    state_d = c_ERROR;
`endif
            default:    state_d = c_FETCH;
        endcase
    end

    // Only the four terminal states retire; each always returns to FETCH.
    assign w_retire = (state_q == c_MEMWB) || (state_q == c_MEMWRITE) ||
                      (state_q == c_ALUWB) || (state_q == c_BEQ);

    always_comb begin
        cnt_d = cnt_q;
        if (w_retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Moore output decode
    always_comb begin
        ALUOp     = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCUpdate  = 1'b0;
        Branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        case (state_q)
            c_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCUpdate  = 1'b1;
            end
            c_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            c_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            c_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            c_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            c_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            c_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            c_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            c_ALUWB: begin
                RegWrite = 1'b1;
            end
            c_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
            end
            c_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q | ((state_q == c_DECODE) && (state_d == c_ERROR));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign IllegalOp = illegal_q;
`else
    assign IllegalOp = 1'b0;
`endif

    assign State      = state_q;
    assign InstrCount = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_main_fsm
//  Purpose  : Scoreboard bench for main_fsm (CNT_W=32 and CNT_W=4 instances).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_main_fsm;

    logic        clk;
    logic        reset;
    logic [6:0]  op;

    logic [1:0]  alu_op, src_a, src_b, res_src;
    logic        adr_src, ir_wr, pc_upd, branch, reg_wr, mem_wr, illegal;
    logic [3:0]  state;
    logic [31:0] cnt;

    logic [1:0]  alu_op4, src_a4, src_b4, res_src4;
    logic        adr_src4, ir_wr4, pc_upd4, branch4, reg_wr4, mem_wr4, illegal4;
    logic [3:0]  state4;
    logic [3:0]  cnt4;

    logic [14:0] obs;
    assign obs = {alu_op, src_a, src_b, res_src, adr_src, ir_wr, pc_upd,
                  branch, reg_wr, mem_wr, illegal};

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op),
        .ALUOp(alu_op), .ALUSrcA(src_a), .ALUSrcB(src_b), .ResultSrc(res_src),
        .AdrSrc(adr_src), .IRWrite(ir_wr), .PCUpdate(pc_upd), .Branch(branch),
        .RegWrite(reg_wr), .MemWrite(mem_wr), .State(state),
        .InstrCount(cnt), .IllegalOp(illegal)
    );

    main_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op),
        .ALUOp(alu_op4), .ALUSrcA(src_a4), .ALUSrcB(src_b4), .ResultSrc(res_src4),
        .AdrSrc(adr_src4), .IRWrite(ir_wr4), .PCUpdate(pc_upd4), .Branch(branch4),
        .RegWrite(reg_wr4), .MemWrite(mem_wr4), .State(state4),
        .InstrCount(cnt4), .IllegalOp(illegal4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] outs;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    // Expected outputs per state:
    // {ALUOp,SrcA,SrcB,ResultSrc,AdrSrc,IRWrite,PCUpdate,Branch,RegWrite,MemWrite,IllegalOp}
    function automatic logic [14:0] exp_outs(input logic [3:0] s);
        case (s)
            4'd0:  return 15'b00_00_10_10_0_1_1_0_0_0_0;
            4'd1:  return 15'b00_01_01_00_0_0_0_0_0_0_0;
            4'd2:  return 15'b00_10_01_00_0_0_0_0_0_0_0;
            4'd3:  return 15'b00_00_00_00_1_0_0_0_0_0_0;
            4'd4:  return 15'b00_00_00_01_0_0_0_0_1_0_0;
            4'd5:  return 15'b00_00_00_00_1_0_0_0_0_1_0;
            4'd6:  return 15'b10_10_00_00_0_0_0_0_0_0_0;
            4'd7:  return 15'b10_10_01_00_0_0_0_0_0_0_0;
            4'd8:  return 15'b00_00_00_00_0_0_0_0_1_0_0;
            4'd9:  return 15'b01_10_00_00_0_0_0_1_0_0_0;
            4'd10: return 15'b00_01_10_00_0_0_1_0_0_0_0;
            4'd11: return 15'b00_00_00_00_0_0_0_0_0_0_1;
            default: return 15'b0;
        endcase
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic check_entry(input exp_t e);
        cmp("state", {28'd0, state}, {28'd0, e.st});
        cmp("outputs", {17'd0, obs}, {17'd0, e.outs});
        cmp("instr_count", cnt, e.cnt);
        cmp("instr_count_w4", {28'd0, cnt4}, {28'd0, e.cnt[3:0]});
    endtask

    // Drive one instruction from FETCH; expected states are queued before the
    // DUT walks them, then consumed one per cycle.
    task automatic run_instr(input logic [6:0] o);
        logic [3:0] seq[$];
        bit retire;
        exp_t e;
        retire = 1'b1;
        case (o)
            7'b0000011: seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            7'b0100011: seq = '{4'd0, 4'd1, 4'd2, 4'd5};
            7'b0110011: seq = '{4'd0, 4'd1, 4'd6, 4'd8};
            7'b0010011: seq = '{4'd0, 4'd1, 4'd7, 4'd8};
            7'b1100011: seq = '{4'd0, 4'd1, 4'd9};
            7'b1101111: seq = '{4'd0, 4'd1, 4'd10, 4'd8};
            default: begin
                seq    = '{4'd0, 4'd1};
                retire = 1'b0;
            end
        endcase
        op = o;
        foreach (seq[i]) begin
            sb.push_back('{st: seq[i], outs: exp_outs(seq[i]), cnt: exp_cnt});
        end
        if (retire) exp_cnt = exp_cnt + 32'd1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_entry(e);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        op    = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_entry('{st: 4'd0, outs: exp_outs(4'd0), cnt: 32'd0});
        reset = 1'b0;

        run_instr(7'b0000011);
        run_instr(7'b0100011);
        run_instr(7'b1100011);
        run_instr(7'b1101111);
        run_instr(7'b0110011);
        run_instr(7'b0010011);
`ifndef ILLEGAL_OP_TRAP_EN
        run_instr(7'b1111111);
`endif
        run_instr(7'b0000011);

        // Asynchronous reset in the middle of a load.
        op = 7'b0000011;
        repeat (3) @(negedge clk);
        cmp("midrd_pre_state", {28'd0, state}, 32'd3);
        #2 reset = 1'b1;
        #1;
        cmp("midrd_state", {28'd0, state}, 32'd0);
        cmp("midrd_irwrite", {31'd0, ir_wr}, 32'd1);
        cmp("midrd_pcupdate", {31'd0, pc_upd}, 32'd1);
        cmp("midrd_count", cnt, 32'd0);
        cmp("midrd_count_w4", {28'd0, cnt4}, 32'd0);
        exp_cnt = 32'd0;
        @(negedge clk);
        reset = 1'b0;

        // Sixteen branches wrap the narrow counter back to zero.
        for (int i = 0; i < 15; i++) run_instr(7'b1100011);
        cmp("wrap_pre_w4", {28'd0, cnt4}, 32'd15);
        run_instr(7'b1100011);
        cmp("wrap_w4", {28'd0, cnt4}, 32'd0);
        cmp("wrap_w32", cnt, 32'd16);

`ifdef ILLEGAL_OP_TRAP_EN
        op = 7'b1111111;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cmp("trap_state", {28'd0, state}, 32'd11);
            cmp("trap_outputs", {17'd0, obs}, {17'd0, exp_outs(4'd11)});
            cmp("trap_count", cnt, exp_cnt);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        cmp("trap_clear_flag", {31'd0, illegal}, 32'd0);
        cmp("trap_clear_state", {28'd0, state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  opcode from instruction register; stable from DECODE until return to FETCH.
REQ-005 ALUOp  output  2  to ALU decoder: 00 add, 01 subtract, 10 funct-decoded.
REQ-006 ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1.
REQ-007 ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4.
REQ-008 ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-009 AdrSrc  output  1  0 PC, 1 Result.
REQ-010 IRWrite, PCUpdate, Branch, RegWrite, MemWrite  output  1 each  enables/strobes.
REQ-011 State  output  4  current state encoding, debug visibility.
REQ-012 InstrCount  output  CNT_W  retired-instruction count.
REQ-013 IllegalOp  output  1  sticky illegal-opcode flag (tied 0 when macro absent).

Function
REQ-014 Moore FSM; outputs SHALL depend only on State; every output not listed for a state SHALL be 0.
REQ-015 Encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, ERROR 11.
REQ-016 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1; next DECODE.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next by op: 0000011/0100011 MEMADR, 0110011 EXECUTER, 0010011 EXECUTEI, 1100011 BEQ, 1101111 JAL, other per REQ-029.
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next MEMREAD if op=0000011, else MEMWRITE.
REQ-019 MEMREAD: ResultSrc=00, AdrSrc=1; next MEMWB. MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-020 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1; next FETCH.
REQ-021 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both next ALUWB.
REQ-022 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-023 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; next FETCH.
REQ-024 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; next ALUWB.
REQ-025 Latency: lw 5 cycles; sw, R-type, I-type ALU, jal 4; beq 3.
REQ-026 InstrCount SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; wraps modulo 2^CNT_W; never increments otherwise.
REQ-027 Any unencoded State value SHALL transition to FETCH next cycle.

Reset
REQ-028 reset asserted (any time, including mid-instruction) SHALL immediately force State=FETCH, InstrCount=0, IllegalOp=0; outputs then take FETCH values; first FETCH exit on first rising edge after reset deasserts.

Configuration
REQ-029 Macro ILLEGAL_OP_TRAP_EN: defined -> unlisted op in DECODE enters ERROR (all enables 0, self-loop) and sets IllegalOp=1, both held until reset; undefined -> unlisted op returns to FETCH, ERROR unreachable, IllegalOp constant 0; neither case increments InstrCount.

Verification
REQ-030 Reset mid-MEMREAD -> State=0, IRWrite=1, PCUpdate=1 during reset, InstrCount=0.
REQ-031 op=0000011 from reset -> States 0,1,2,3,4,0; RegWrite=1 only in 4 with ResultSrc=01; InstrCount=1.
REQ-032 op=0100011 -> 0,1,2,5,0; MemWrite=1 single cycle; op=1100011 -> 0,1,9,0 with ALUOp=01, Branch=1.
REQ-033 op=1101111 -> 0,1,10,8,0; PCUpdate=1 in 0 and 10; op=0110011 -> 0,1,6,8,0 with ALUOp=10.
REQ-034 CNT_W=4, 16 retired beq -> InstrCount wraps 15 -> 0.
REQ-035 op=1111111: with ILLEGAL_OP_TRAP_EN -> State=11, IllegalOp=1 held until reset; without -> 0,1,0, IllegalOp=0, InstrCount unchanged.
